keypad_hex_scanner: RTL

KEYPAD_HEX_SCANNER -- requirements
Module: keypad_hex_scanner

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_tick_gen.sv | 32 +++
 rtl/keypad_hex_scanner.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_RELEASE
  } scan_state_t;

  // Default timing: 0.5 ms scan tick at 100 MHz, four matching samples.
  localparam int DEFAULT_SCAN_DIV       = 50000;
  localparam int DEFAULT_DEBOUNCE_TICKS = 4;

  // 16-entry key map, nibble index {row, col}. Entry 0 sits in bits [3:0].
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E(*) 0 F(#) D
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  // Hex code for the key at (row, col).
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] idx;
    idx = {row, col};
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running SCAN_DIV divider producing a one-cycle scan-tick enable.
module keypad_tick_gen
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
  input  logic clk_pi,
  input  logic rst_pi,
  output logic tick_po
);

  localparam int                CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..SCAN_DIV-1 and wrap.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The tick is a clock enable for the scanner, high on the wrap cycle.
  assign tick_po = (cnt == CNT_LAST);

endmodule

// File: rtl/keypad_hex_scanner.sv
// 4x4 matrix keypad scanner: column drive, row debounce, key commit
// into a four-deep nibble history with valid/overflow flags.
module keypad_hex_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic        clk_pi,
  input  logic        rst_pi,
  input  logic [3:0]  row_pi,
  input  logic        ack_pi,
  input  logic        clr_pi,
  output logic [3:0]  col_po,
  output logic [15:0] data_po,
  output logic [3:0]  key_po,
  output logic        valid_po,
  output logic        ovf_po
);

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS);

  logic [3:0]  row_meta;
  logic [3:0]  row_sync;
  logic        tick;
  scan_state_t state;
  logic [1:0]  col_idx;
  logic [1:0]  cand_row;
  logic [3:0]  db_cnt;
  logic        row_hit;
  logic [1:0]  row_idx;
  logic        commit;
  logic [3:0]  commit_code;

  keypad_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk_pi  (clk_pi),
    .rst_pi  (rst_pi),
    .tick_po (tick)
  );

  // Two-flop synchronizer for the asynchronous rows; idle is all-high.
  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_pi;
      row_sync <= row_meta;
    end
  end

  // Decode exactly one low row; none or several low count as no key.
  // NOTE: defaults first so every path assigns and no latch is inferred.
  always_comb begin
    row_hit = 1'b0;
    row_idx = 2'd0;
    case (row_sync)
      4'b1110: begin row_hit = 1'b1; row_idx = 2'd0; end
      4'b1101: begin row_hit = 1'b1; row_idx = 2'd1; end
      4'b1011: begin row_hit = 1'b1; row_idx = 2'd2; end
      4'b0111: begin row_hit = 1'b1; row_idx = 2'd3; end
      default: ;
    endcase
  end

  // Commit when the tick completes debounce (directly from SCAN if one sample suffices).
  always_comb begin
    commit = 1'b0;
    if (tick && row_hit) begin
      case (state)
        ST_SCAN:     commit = (DEBOUNCE_TICKS == 1);
        ST_DEBOUNCE: commit = (row_idx == cand_row) && ((db_cnt + 4'd1) == DB_LAST);
        default:     commit = 1'b0;
      endcase
    end
    // Column is frozen while debouncing, so the live column is the candidate's.
    commit_code = key_code(row_idx, col_idx);
  end

  // Scan / debounce / release FSM with the registered column drive.
  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      state    <= ST_SCAN;
      col_idx  <= 2'd0;
      col_po   <= 4'b1110;
      cand_row <= 2'd0;
      db_cnt   <= 4'd0;
    end else if (tick) begin
      case (state)
        ST_SCAN: begin
          if (row_hit) begin
            cand_row <= row_idx;
            if (commit) begin
              state  <= ST_RELEASE;
              db_cnt <= 4'd0;
            end else begin
              state  <= ST_DEBOUNCE;
              db_cnt <= 4'd1;
            end
          end else begin
            col_idx <= col_idx + 1'b1;
            col_po  <= {col_po[2:0], col_po[3]};
          end
        end
        ST_DEBOUNCE: begin
          if (row_hit && (row_idx == cand_row)) begin
            if (commit) begin
              state  <= ST_RELEASE;
              db_cnt <= 4'd0;
            end else begin
              db_cnt <= db_cnt + 4'd1;
            end
          end else begin
            state   <= ST_SCAN;
            db_cnt  <= 4'd0;
            col_idx <= col_idx + 1'b1;
            col_po  <= {col_po[2:0], col_po[3]};
          end
        end
        ST_RELEASE: begin
          if (row_sync == 4'hF) begin
            if ((db_cnt + 4'd1) == DB_LAST) begin
              state   <= ST_SCAN;
              db_cnt  <= 4'd0;
              col_idx <= col_idx + 1'b1;
              col_po  <= {col_po[2:0], col_po[3]};
            end else begin
              db_cnt <= db_cnt + 4'd1;
            end
          end else begin
            db_cnt <= 4'd0;
          end
        end
        default: begin
          state  <= ST_SCAN;
          db_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Commit history, key, and CPU handshake flags.
  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      data_po  <= 16'h0000;
      key_po   <= 4'h0;
      valid_po <= 1'b0;
      ovf_po   <= 1'b0;
    end else begin
      if (commit) begin
        data_po <= clr_pi ? {12'h000, commit_code} : {data_po[11:0], commit_code};
      end else if (clr_pi) begin
        data_po <= 16'h0000;
      end

      if (commit) begin
        key_po <= commit_code;
      end

      if (commit) begin
        valid_po <= 1'b1;
        ovf_po   <= ack_pi ? 1'b0 : (ovf_po | valid_po);
      end else if (ack_pi) begin
        valid_po <= 1'b0;
        ovf_po   <= 1'b0;
      end
    end
  end

endmodule
